mem_bus_datapath: RTL and testbench

Parametrised register-file datapath with a MAR/MDR memory port and a command sequencer. It is the next-generation replacement for the fixed 16×32 bus datapath. Each accepted command (register move, immediate load, memory load, memory store) runs as a multi-cycle micro-sequence over one internal bus. The external memory handshake supports variable wait states and a timeout abort.

---
 rtl/mem_bus_datapath.sv | 114 +++++++++++
 tb/tb_mem_bus_datapath.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_datapath.sv
// mem_bus_datapath: register file plus MAR/MDR memory port, driven by a command sequencer.
// Each command runs as a short micro-sequence (IDLE -> EXEC -> [MEM -> [WB]] -> IDLE).
module mem_bus_datapath #(
   parameter int WIDTH   = 32,
   parameter int NREGS   = 16,
   parameter int IDX_W   = 4,
   parameter int ADDR_W  = 9,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [IDX_W-1:0]  cmd_dst,
   input  logic [IDX_W-1:0]  cmd_src,
   input  logic              cmd_ba,
   input  logic [WIDTH-1:0]  cmd_imm,
   output logic              done,
   output logic              err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WIDTH-1:0]  mem_wdata,
   input  logic [WIDTH-1:0]  mem_rdata,
   input  logic              mem_ack,
   input  logic [IDX_W-1:0]  dbg_sel,
   output logic [WIDTH-1:0]  dbg_data
);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [IDX_W:0] NR = (IDX_W+1)'(NREGS);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
   typedef enum logic [1:0] {IDLE, EXEC, MEM, WB} state_t;
   state_t r_state, w_next;
   logic [1:0]        r_op;
   logic [IDX_W-1:0]  r_dst, r_src;
   logic              r_ba, r_done, r_err;
   logic [WIDTH-1:0]  r_imm, r_mdr;
   logic [ADDR_W-1:0] r_mar;
   logic [CW-1:0]     r_cnt;
   logic [WIDTH-1:0]  r_regs [NREGS];
   logic [WIDTH-1:0]  w_src, w_base, w_wdata;
   logic              w_tmo, w_we;

   // out-of-range indices read as zero
   function automatic logic [WIDTH-1:0] rd(input logic [IDX_W-1:0] i);
      return ({1'b0, i} < NR) ? r_regs[i] : '0;
   endfunction

   assign cmd_ready = (r_state == IDLE);
   assign mem_req   = (r_state == MEM);
   assign mem_we    = mem_req & r_op[0];
   assign mem_addr  = r_mar;
   assign mem_wdata = r_mdr;
   assign dbg_data  = rd(dbg_sel);
   assign done      = r_done;
   assign err       = r_err;
   assign w_src     = rd(r_src);
   assign w_base    = (r_ba && r_src == '0) ? '0 : w_src;
   assign w_tmo     = mem_req & ~mem_ack & (r_cnt == LAST);
   assign w_we      = ((r_state == EXEC && !r_op[1]) || r_state == WB) && ({1'b0, r_dst} < NR);
   assign w_wdata   = (r_state == WB) ? r_mdr : r_op[0] ? r_imm : w_src;

   always_ff @(posedge clk or posedge clr)
      if (clr) r_state <= IDLE;
      else r_state <= w_next;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = cmd_valid ? EXEC : IDLE;
         EXEC:    w_next = r_op[1] ? MEM : IDLE;
         MEM:     w_next = mem_ack ? (r_op[0] ? IDLE : WB) : (w_tmo ? IDLE : MEM);
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge clr)
      if (clr) for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      else if (w_we) r_regs[r_dst] <= w_wdata;

   always_ff @(posedge clk or posedge clr)
      if (clr) begin
         r_op   <= '0;
         r_dst  <= '0;
         r_src  <= '0;
         r_ba   <= 1'b0;
         r_imm  <= '0;
         r_mar  <= '0;
         r_mdr  <= '0;
         r_cnt  <= '0;
         r_done <= 1'b0;
         r_err  <= 1'b0;
      end else begin
         r_done <= (r_state == EXEC && !r_op[1]) || r_state == WB || (mem_req && mem_ack && r_op[0]);
         r_err  <= w_tmo;
         if (cmd_valid && cmd_ready) begin
            r_op  <= cmd_op;
            r_dst <= cmd_dst;
            r_src <= cmd_src;
            r_ba  <= cmd_ba;
            r_imm <= cmd_imm;
         end
         if (r_state == EXEC && r_op[1]) begin
            r_mar <= ADDR_W'(w_base + r_imm);
            r_cnt <= '0;
            if (r_op[0]) r_mdr <= rd(r_dst);
         end
         if (mem_req) begin
            if (mem_ack && !r_op[0]) r_mdr <= mem_rdata;
            if (!mem_ack && !w_tmo) r_cnt <= r_cnt + 1'b1;
         end
      end
endmodule

// File: tb/tb_mem_bus_datapath.sv
// tb_mem_bus_datapath: table vectors, reset corner sequences and random commands
// compared against a behavioural register/memory model.
module tb_mem_bus_datapath;
   localparam int NR = 12, TMO = 8;
   logic clk = 0, clr = 1, cmd_valid = 0, cmd_ba = 0, mem_ack = 0;
   logic cmd_ready, done, err, mem_req, mem_we;
   logic [1:0]  cmd_op = 0;
   logic [3:0]  cmd_dst = 0, cmd_src = 0, dbg_sel = 0;
   logic [31:0] cmd_imm = 0, mem_rdata = 0, mem_wdata, dbg_data;
   logic [8:0]  mem_addr;
   int checks = 0, errors = 0;
   logic [31:0] m [NR];
   logic [31:0] mdr;
   logic [31:0] tb_mem [512];

   typedef struct {
      logic [1:0]  op;
      logic [3:0]  dst, src;
      logic        ba;
      logic [31:0] imm;
      int          waits, e_edges;
      logic [8:0]  e_addr;
      logic [31:0] e_reg;
   } vec_t;
   vec_t tbl [11];

   always #5 clk = ~clk;

   mem_bus_datapath #(.WIDTH(32), .NREGS(NR), .IDX_W(4), .ADDR_W(9), .TIMEOUT(TMO)) dut (
      .clk(clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_dst(cmd_dst), .cmd_src(cmd_src), .cmd_ba(cmd_ba), .cmd_imm(cmd_imm), .done(done),
      .err(err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .dbg_sel(dbg_sel), .dbg_data(dbg_data));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mrd(input logic [3:0] i);
      return (int'(i) < NR) ? m[i] : 32'h0;
   endfunction

   task automatic mwr(input logic [3:0] i, input logic [31:0] v);
      if (int'(i) < NR) m[i] = v;
   endtask

   // waits: wait cycles before ack (-1 = never acks); noise drives ignored cmd/ack traffic
   task automatic run(input logic [1:0] op, input logic [3:0] dst, input logic [3:0] src,
                      input logic ba, input logic [31:0] imm, input int waits, input bit noise,
                      output int edges, output logic [8:0] addr);
      logic [31:0] base, mdr_mem, rdv;
      logic [8:0] ea;
      int nm, bad, exp_nm, exp_edges;
      bit acked, tmo;
      base = (ba && src == 4'd0) ? 32'h0 : mrd(src);
      ea = 9'(base + imm);
      acked = waits >= 0 && waits < TMO;
      tmo = op[1] && !acked;
      exp_nm = acked ? waits + 1 : TMO;
      exp_edges = !op[1] ? 1 : tmo ? 1 + TMO : op[0] ? 1 + exp_nm : 2 + exp_nm;
      mdr_mem = (op == 2'b11) ? mrd(dst) : mdr;
      rdv = tb_mem[ea];
      chk("ready_idle", {31'h0, cmd_ready}, 32'h1);
      cmd_valid = 1; cmd_op = op; cmd_dst = dst; cmd_src = src; cmd_ba = ba; cmd_imm = imm;
      @(posedge clk); #1;
      chk("pulse_len", {30'h0, done, err}, 32'h0);
      cmd_valid = noise; cmd_op = 2'b01; cmd_dst = 4'($urandom_range(0, NR - 1)); cmd_imm = $urandom;
      mem_ack = noise & 1'($urandom);
      edges = 0; nm = 0; bad = 0; addr = '0;
      while (edges < 400) begin
         @(posedge clk); #1;
         edges++;
         if (done || err) break;
         if (mem_req) begin
            nm++;
            addr = mem_addr;
            if (mem_addr !== ea || mem_we !== op[0] || mem_wdata !== mdr_mem) bad++;
            mem_ack = (waits >= 0 && nm == waits + 1);
            mem_rdata = $urandom;
            if (mem_ack) begin
               mem_rdata = tb_mem[mem_addr];
               if (op[0]) tb_mem[mem_addr] = mem_wdata;
            end
         end else mem_ack = noise & 1'($urandom);
      end
      cmd_valid = 0; mem_ack = 0;
      chk("edges", edges, exp_edges);
      chk("done", {31'h0, done}, {31'h0, ~tmo});
      chk("err", {31'h0, err}, {31'h0, tmo});
      chk("ready_done", {31'h0, cmd_ready}, 32'h1);
      if (op[1]) begin
         chk("mem_cycles", nm, exp_nm);
         chk("mem_bus", bad, 0);
      end
      case (op)
         2'b00: mwr(dst, mrd(src));
         2'b01: mwr(dst, imm);
         2'b10: if (!tmo) begin mdr = rdv; mwr(dst, rdv); end
         default: mdr = mrd(dst);
      endcase
      dbg_sel = dst; #1;
      chk("dbg_dst", dbg_data, mrd(dst));
   endtask

   initial begin
      int edges;
      logic [8:0] addr;
      for (int i = 0; i < 512; i++) tb_mem[i] = $urandom;
      tb_mem[9'h044] = 32'hDEADBEEF;
      tb_mem[9'h035] = 32'hCAFEF00D;
      for (int i = 0; i < NR; i++) m[i] = 0;
      mdr = 0;
      tbl[0]  = '{2'd1, 4'd3, 4'd0, 1'b0, 32'h1234, 0, 1, 9'h0, 32'h1234};
      tbl[1]  = '{2'd1, 4'd4, 4'd0, 1'b0, 32'h01F0, 0, 1, 9'h0, 32'h01F0};
      tbl[2]  = '{2'd0, 4'd5, 4'd3, 1'b0, 32'h0, 0, 1, 9'h0, 32'h1234};
      tbl[3]  = '{2'd0, 4'd3, 4'd3, 1'b0, 32'h0, 0, 1, 9'h0, 32'h1234};
      tbl[4]  = '{2'd3, 4'd3, 4'd4, 1'b0, 32'h20, 3, 5, 9'h010, 32'h1234};
      tbl[5]  = '{2'd1, 4'd0, 4'd0, 1'b0, 32'h100, 0, 1, 9'h0, 32'h100};
      tbl[6]  = '{2'd2, 4'd7, 4'd0, 1'b1, 32'h44, 0, 3, 9'h044, 32'hDEADBEEF};
      tbl[7]  = '{2'd2, 4'd7, 4'd4, 1'b0, 32'h0, -1, 9, 9'h1F0, 32'hDEADBEEF};
      tbl[8]  = '{2'd2, 4'd6, 4'd5, 1'b0, 32'h1, 7, 10, 9'h035, 32'hCAFEF00D};
      tbl[9]  = '{2'd3, 4'd5, 4'd0, 1'b0, 32'h0, 0, 2, 9'h100, 32'h1234};
      tbl[10] = '{2'd2, 4'd1, 4'd0, 1'b0, 32'h0, 0, 3, 9'h100, 32'h1234};
      #12;
      chk("rst_flags", {26'h0, done, err, mem_req, mem_we, 2'b0}, 32'h0);
      chk("rst_addr", {23'h0, mem_addr}, 32'h0);
      chk("rst_wdata", mem_wdata, 32'h0);
      @(posedge clk); #1;
      clr = 0; #1;
      chk("rst_ready", {31'h0, cmd_ready}, 32'h1);
      for (int i = 0; i < 16; i++) begin
         dbg_sel = 4'(i); #1;
         chk("rst_reg", dbg_data, 32'h0);
      end
      @(posedge clk); #1;
      for (int i = 0; i < 11; i++) begin
         run(tbl[i].op, tbl[i].dst, tbl[i].src, tbl[i].ba, tbl[i].imm, tbl[i].waits, 1'b0, edges, addr);
         chk("tbl_edges", edges, tbl[i].e_edges);
         if (tbl[i].op[1]) chk("tbl_addr", {23'h0, addr}, {23'h0, tbl[i].e_addr});
         dbg_sel = tbl[i].dst; #1;
         chk("tbl_reg", dbg_data, tbl[i].e_reg);
      end
      // reset while a load waits in MEM
      cmd_valid = 1; cmd_op = 2'b10; cmd_dst = 4'd2; cmd_src = 4'd0; cmd_ba = 1; cmd_imm = 32'h5;
      @(posedge clk); #1;
      cmd_valid = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("mid_mem_req", {31'h0, mem_req}, 32'h1);
      #3 clr = 1;
      #1;
      chk("async_req_drop", {31'h0, mem_req}, 32'h0);
      chk("async_pulses", {30'h0, done, err}, 32'h0);
      @(posedge clk); #1;
      chk("rst_pulses", {30'h0, done, err}, 32'h0);
      for (int i = 0; i < 16; i++) begin
         dbg_sel = 4'(i); #1;
         chk("mid_rst_reg", dbg_data, 32'h0);
      end
      clr = 0;
      for (int i = 0; i < NR; i++) m[i] = 0;
      mdr = 0;
      @(posedge clk); #1;
      chk("post_rst_ready", {31'h0, cmd_ready}, 32'h1);
      chk("post_rst_bus", {mem_addr, 23'h0} | mem_wdata, 32'h0);
      for (int k = 0; k < 150; k++)
         run(2'($urandom), 4'($urandom), 4'($urandom), 1'($urandom_range(0, 3) == 0),
             $urandom, int'($urandom_range(0, 11)) - 1, 1'($urandom), edges, addr);
      for (int i = 0; i < 16; i++) begin
         dbg_sel = 4'(i); #1;
         chk("final_reg", dbg_data, mrd(4'(i)));
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
